// File: rtl/banked_mshr_scheduler.sv
// Multi-port, multi-bank miss scheduler. Each bank holds a circular MSHR queue with
// alloc/dispatch/retire pointers, and incoming ports are arbitrated round-robin per bank.
module banked_mshr_scheduler #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned MSHR_DEPTH     = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned BYTE_OFF_BITS  = 2,
  parameter int unsigned BLOCK_OFF_BITS = 2,
  localparam int unsigned BANK_W        = $clog2(NUM_BANKS),
  localparam int unsigned SLOT_W        = $clog2(MSHR_DEPTH),
  localparam int unsigned PTR_W         = SLOT_W + 1,
  localparam int unsigned UUID_W        = BANK_W + SLOT_W
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS-1:0]                 req_rw,
  input  logic [NUM_PORTS-1:0][31:0]           req_store,
  output logic [NUM_PORTS-1:0]                 req_ready,
  output logic [NUM_PORTS-1:0][UUID_W-1:0]     req_uuid,
  output logic                                 stall,
  output logic [NUM_BANKS-1:0]                 bank_req_valid,
  output logic [NUM_BANKS-1:0][ADDR_W-1:0]     bank_req_addr,
  output logic [NUM_BANKS-1:0]                 bank_req_rw,
  output logic [NUM_BANKS-1:0][31:0]           bank_req_store,
  output logic [NUM_BANKS-1:0][UUID_W-1:0]     bank_req_uuid,
  input  logic [NUM_BANKS-1:0]                 bank_req_ready,
  input  logic [NUM_BANKS-1:0]                 bank_done,
  output logic [NUM_BANKS-1:0]                 retire_valid,
  output logic [NUM_BANKS-1:0][UUID_W-1:0]     retire_uuid,
  output logic [NUM_BANKS-1:0][PTR_W-1:0]      occupancy,
  output logic                                 err
);

  localparam int unsigned RR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BANK_LSB = BYTE_OFF_BITS + BLOCK_OFF_BITS;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(MSHR_DEPTH);

  logic [ADDR_W-1:0] mem_addr  [NUM_BANKS][MSHR_DEPTH];
  logic              mem_rw    [NUM_BANKS][MSHR_DEPTH];
  logic [31:0]       mem_store [NUM_BANKS][MSHR_DEPTH];

  logic [NUM_BANKS-1:0][PTR_W-1:0] alloc_q, disp_q, ret_q;
  logic [NUM_BANKS-1:0][RR_W-1:0]  rr_q, rr_nxt;
  logic                            err_q;

  logic [NUM_PORTS-1:0][BANK_W-1:0] req_bank;
  logic [NUM_BANKS-1:0]             win_found, accept, dispatch, retire, spurious;
  logic [NUM_BANKS-1:0][RR_W-1:0]   win_port;
  logic [NUM_BANKS-1:0][PTR_W-1:0]  occ, pending, inflight;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_bank[p] = req_addr[p][BANK_LSB +: BANK_W];
    end
  end

  // Round-robin scan per bank, starting at that bank's rr pointer.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      win_found[b] = 1'b0;
      win_port[b]  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = (int'(rr_q[b]) + k) % NUM_PORTS;
        if (!win_found[b] && req_valid[idx] && (req_bank[idx] == BANK_W'(b))) begin
          win_found[b] = 1'b1;
          win_port[b]  = RR_W'(idx);
        end
      end
      rr_nxt[b] = RR_W'((int'(win_port[b]) + 1) % NUM_PORTS);
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      occ[b]      = alloc_q[b] - ret_q[b];
      pending[b]  = alloc_q[b] - disp_q[b];
      inflight[b] = disp_q[b] - ret_q[b];
      // Registered occupancy only: a same-cycle retire never frees room for an accept.
      accept[b]   = !RST && win_found[b] && (occ[b] < DEPTH_P);
      dispatch[b] = !RST && (pending[b] != '0) && bank_req_ready[b];
      retire[b]   = !RST && bank_done[b] && (inflight[b] != '0);
      spurious[b] = !RST && bank_done[b] && (inflight[b] == '0);
    end
  end

  always_comb begin
    req_ready = '0;
    req_uuid  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[b] && (win_port[b] == RR_W'(p))) begin
          req_ready[p] = 1'b1;
          req_uuid[p]  = {BANK_W'(b), alloc_q[b][SLOT_W-1:0]};
        end
      end
    end
    stall = !RST && |(req_valid & ~req_ready);
  end

  always_comb begin
    bank_req_valid = '0;
    bank_req_addr  = '0;
    bank_req_rw    = '0;
    bank_req_store = '0;
    bank_req_uuid  = '0;
    retire_valid   = '0;
    retire_uuid    = '0;
    occupancy      = '0;
    err            = 1'b0;
    if (!RST) begin
      err = err_q;
      for (int b = 0; b < NUM_BANKS; b++) begin
        occupancy[b] = occ[b];
        if (pending[b] != '0) begin
          bank_req_valid[b] = 1'b1;
          bank_req_addr[b]  = mem_addr[b][disp_q[b][SLOT_W-1:0]];
          bank_req_rw[b]    = mem_rw[b][disp_q[b][SLOT_W-1:0]];
          bank_req_store[b] = mem_store[b][disp_q[b][SLOT_W-1:0]];
          bank_req_uuid[b]  = {BANK_W'(b), disp_q[b][SLOT_W-1:0]};
        end
        if (retire[b]) begin
          retire_valid[b] = 1'b1;
          retire_uuid[b]  = {BANK_W'(b), ret_q[b][SLOT_W-1:0]};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      alloc_q <= '0;
      disp_q  <= '0;
      ret_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (accept[b]) begin
          alloc_q[b] <= alloc_q[b] + PTR_W'(1);
          rr_q[b]    <= rr_nxt[b];
        end
        if (dispatch[b]) disp_q[b] <= disp_q[b] + PTR_W'(1);
        if (retire[b])   ret_q[b]  <= ret_q[b] + PTR_W'(1);
      end
      if (|spurious) err_q <= 1'b1;
    end
  end

  // Entry storage is not reset; accept is already gated off while RST is high.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (accept[b]) begin
        mem_addr[b][alloc_q[b][SLOT_W-1:0]]  <= req_addr[win_port[b]];
        mem_rw[b][alloc_q[b][SLOT_W-1:0]]    <= req_rw[win_port[b]];
        mem_store[b][alloc_q[b][SLOT_W-1:0]] <= req_store[win_port[b]];
      end
    end
  end

endmodule

// File: tb/tb_banked_mshr_scheduler.sv
// Bench for banked_mshr_scheduler: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of pending and in-flight entries per bank.
module tb_banked_mshr_scheduler;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int D  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        req_valid;
  logic [1:0][31:0]  req_addr;
  logic [1:0]        req_rw;
  logic [1:0][31:0]  req_store;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_uuid;
  logic              stall;
  logic [3:0]        bank_req_valid;
  logic [3:0][31:0]  bank_req_addr;
  logic [3:0]        bank_req_rw;
  logic [3:0][31:0]  bank_req_store;
  logic [3:0][3:0]   bank_req_uuid;
  logic [3:0]        bank_req_ready;
  logic [3:0]        bank_done;
  logic [3:0]        retire_valid;
  logic [3:0][3:0]   retire_uuid;
  logic [3:0][2:0]   occupancy;
  logic              err;

  banked_mshr_scheduler #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .MSHR_DEPTH(D), .ADDR_W(32),
    .BYTE_OFF_BITS(2), .BLOCK_OFF_BITS(2)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw), .req_store(req_store),
    .req_ready(req_ready), .req_uuid(req_uuid), .stall(stall),
    .bank_req_valid(bank_req_valid), .bank_req_addr(bank_req_addr),
    .bank_req_rw(bank_req_rw), .bank_req_store(bank_req_store),
    .bank_req_uuid(bank_req_uuid), .bank_req_ready(bank_req_ready),
    .bank_done(bank_done), .retire_valid(retire_valid), .retire_uuid(retire_uuid),
    .occupancy(occupancy), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] store;
    logic [3:0]  uuid;
  } ent_t;

  ent_t pq [NB][$];
  ent_t iq [NB][$];
  int   rr [NB];
  int   alloc_cnt [NB];
  bit   err_m;

  bit   e_acc [NB];
  bit   e_disp [NB];
  bit   e_ret [NB];
  bit   e_spur [NB];
  int   e_win [NB];
  int   e_uuid [NP];

  int tests = 0;
  int fails = 0;

  function automatic int bank_of(input logic [31:0] a);
    return int'((a >> 4) % NB);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: derive expected outputs from the model and compare.
  task automatic settle();
    logic [1:0] er;
    logic [3:0] bv;
    bit found;
    int p;
    @(negedge CLK);
    er = '0;
    bv = '0;
    for (int b = 0; b < NB; b++) begin
      e_acc[b] = 0; e_disp[b] = 0; e_ret[b] = 0; e_spur[b] = 0; e_win[b] = 0;
      if (!RST) begin
        found = 0;
        for (int k = 0; k < NP; k++) begin
          p = (rr[b] + k) % NP;
          if (!found && req_valid[p] && bank_of(req_addr[p]) == b) begin
            found = 1;
            e_win[b] = p;
          end
        end
        if (found && (pq[b].size() + iq[b].size()) < D) begin
          e_acc[b] = 1;
          er[e_win[b]] = 1'b1;
          e_uuid[e_win[b]] = b * D + alloc_cnt[b] % D;
        end
        bv[b]     = pq[b].size() > 0;
        e_disp[b] = bv[b] && bank_req_ready[b];
        e_ret[b]  = bank_done[b] && iq[b].size() > 0;
        e_spur[b] = bank_done[b] && iq[b].size() == 0;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    for (int q = 0; q < NP; q++) if (er[q]) chk("req_uuid", 64'(req_uuid[q]), 64'(e_uuid[q]));
    chk("stall", 64'(stall), RST ? 64'd0 : 64'(|(req_valid & ~er)));
    chk("bank_req_valid", 64'(bank_req_valid), 64'(bv));
    for (int b = 0; b < NB; b++) begin
      if (bv[b]) begin
        chk("bank_req_addr", 64'(bank_req_addr[b]), 64'(pq[b][0].addr));
        chk("bank_req_rw", 64'(bank_req_rw[b]), 64'(pq[b][0].rw));
        chk("bank_req_store", 64'(bank_req_store[b]), 64'(pq[b][0].store));
        chk("bank_req_uuid", 64'(bank_req_uuid[b]), 64'(pq[b][0].uuid));
      end
      chk("retire_valid", 64'(retire_valid[b]), 64'(e_ret[b]));
      if (e_ret[b]) chk("retire_uuid", 64'(retire_uuid[b]), 64'(iq[b][0].uuid));
      chk("occupancy", 64'(occupancy[b]), RST ? 64'd0 : 64'(pq[b].size() + iq[b].size()));
    end
    chk("err", 64'(err), RST ? 64'd0 : 64'(err_m));
  endtask

  task automatic tick();
    int p;
    @(posedge CLK);
    if (RST) begin
      for (int b = 0; b < NB; b++) begin
        pq[b].delete(); iq[b].delete(); rr[b] = 0; alloc_cnt[b] = 0;
      end
      err_m = 0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (e_ret[b]) void'(iq[b].pop_front());
        if (e_disp[b]) iq[b].push_back(pq[b].pop_front());
        if (e_acc[b]) begin
          p = e_win[b];
          pq[b].push_back({req_addr[p], req_rw[p], req_store[p], 4'(e_uuid[p])});
          alloc_cnt[b]++;
          rr[b] = (p + 1) % NP;
        end
        if (e_spur[b]) err_m = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_rw = '0; req_store = '0;
    bank_req_ready = '0; bank_done = '0;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin rr[b] = 0; alloc_cnt[b] = 0; end
    err_m = 0;
    idle_inputs();

    // Reset with requests present.
    RST = 1'b1;
    req_valid = 2'b11; req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_bank_valid", 64'(bank_req_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      tick();
    end
    RST = 1'b0;
    idle_inputs();

    // First accept into bank 1.
    req_valid = 2'b01; req_addr[0] = 32'h0000_0010; req_store[0] = 32'hCAFE_0001;
    settle();
    chk("first_ready", 64'(req_ready[0]), 64'd1);
    chk("first_uuid", 64'(req_uuid[0]), 64'h4);
    tick();
    idle_inputs();
    settle();
    chk("first_disp_valid", 64'(bank_req_valid[1]), 64'd1);
    chk("first_disp_addr", 64'(bank_req_addr[1]), 64'h10);
    chk("first_occ", 64'(occupancy[1]), 64'd1);
    tick();
    bank_req_ready[1] = 1'b1; settle(); tick(); bank_req_ready[1] = 1'b0;
    bank_done[1] = 1'b1; settle(); tick(); bank_done[1] = 1'b0;

    // Two ports contending for bank 2.
    req_valid = 2'b11; req_addr[0] = 32'h20; req_addr[1] = 32'h24;
    req_store[0] = 32'h1111_0000; req_store[1] = 32'h2222_0000; req_rw = 2'b10;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("arb_ready", 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
      chk("arb_uuid", 64'(req_uuid[i % 2]), 64'(8 + i));
      tick();
    end
    settle();
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_stall", 64'(stall), 64'd1);
    chk("full_occ", 64'(occupancy[2]), 64'd4);
    tick();

    // Retire while full does not open a slot until the next cycle.
    idle_inputs();
    bank_req_ready[2] = 1'b1;
    settle(); tick(); settle(); tick();
    bank_req_ready[2] = 1'b0;
    req_valid = 2'b01; req_addr[0] = 32'h20; bank_done[2] = 1'b1;
    settle();
    chk("full_retire_uuid", 64'(retire_uuid[2]), 64'h8);
    chk("full_retire_valid", 64'(retire_valid[2]), 64'd1);
    chk("full_retire_noready", 64'(req_ready[0]), 64'd0);
    tick();
    bank_done[2] = 1'b0;
    settle();
    chk("wrap_ready", 64'(req_ready[0]), 64'd1);
    chk("wrap_uuid", 64'(req_uuid[0]), 64'h8);
    tick();
    idle_inputs();

    // Independent banks accept together.
    req_valid = 2'b11; req_addr[0] = 32'h00; req_addr[1] = 32'h30;
    settle();
    chk("par_ready", 64'(req_ready), 64'b11);
    chk("par_uuid0", 64'(req_uuid[0]), 64'h0);
    chk("par_uuid1", 64'(req_uuid[1]), 64'hC);
    tick();
    idle_inputs();

    // Completion with nothing in flight.
    bank_done[1] = 1'b1;
    settle();
    chk("spur_retire", 64'(retire_valid[1]), 64'd0);
    tick();
    bank_done[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("spur_err", 64'(err), 64'd1);
      tick();
    end

    // Three entries live in bank 0, then reset.
    req_valid = 2'b01; req_addr[0] = 32'h40;
    settle(); tick(); settle(); tick();
    idle_inputs();
    bank_req_ready[0] = 1'b1; settle(); tick(); bank_req_ready[0] = 1'b0;
    settle();
    chk("pre_rst_occ", 64'(occupancy[0]), 64'd3);
    tick();
    RST = 1'b1; settle(); tick(); RST = 1'b0;
    settle();
    chk("post_rst_occ", 64'(occupancy[0]), 64'd0);
    chk("post_rst_valid", 64'(bank_req_valid[0]), 64'd0);
    chk("post_rst_err", 64'(err), 64'd0);
    tick();
    req_valid = 2'b01; req_addr[0] = 32'h0;
    settle();
    chk("post_rst_uuid", 64'(req_uuid[0]), 64'h0);
    chk("post_rst_ready", 64'(req_ready[0]), 64'd1);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      RST            = ($urandom_range(0, 79) == 0);
      req_valid      = 2'($urandom);
      req_addr[0]    = $urandom;
      req_addr[1]    = $urandom;
      req_rw         = 2'($urandom);
      req_store[0]   = $urandom;
      req_store[1]   = $urandom;
      bank_req_ready = 4'($urandom);
      bank_done      = 4'($urandom) & 4'($urandom);
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/banked_mshr_scheduler.md
# banked_mshr_scheduler

Multi-port, multi-bank miss scheduler for the lockup-free cache. It accepts miss requests from NUM_PORTS lookup pipelines per cycle and routes each one by address to a per-bank MSHR queue of MSHR_DEPTH entries. Per-bank contention is resolved round-robin. Each accepted request gets a UUID, and queued entries are dispatched in order to the bank's RAM-side engine over a valid/ready handshake. An entry is retired when the bank signals completion. It generalises the single-port, depth-fixed MSHR front end, adding port arbitration, configurable depth, and explicit dispatch/retire tracking.

## Interface
- NUM_PORTS, 2, request ports (≥1)
- NUM_BANKS, 4, banks (power of 2, ≥2)
- MSHR_DEPTH, 4, entries per bank (power of 2, ≥2)
- ADDR_W, 32, address width
- BYTE_OFF_BITS, 2, byte-offset bits
- BLOCK_OFF_BITS, 2, block-offset bits
- UUID_W, log2(NUM_BANKS)+log2(MSHR_DEPTH), derived; not overridable

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- req_valid  in  [NUM_PORTS]  miss request present
- req_addr  in  [NUM_PORTS][ADDR_W]  request address
- req_rw  in  [NUM_PORTS]  0 = read, 1 = write
- req_store  in  [NUM_PORTS][32]  store data
- req_ready  out  [NUM_PORTS]  request accepted this cycle
- req_uuid  out  [NUM_PORTS][UUID_W]  assigned UUID; meaningful when valid&ready
- stall  out  1  OR over ports of (req_valid & ~req_ready)
- bank_req_valid  out  [NUM_BANKS]  head pending entry available
- bank_req_addr / bank_req_rw / bank_req_store / bank_req_uuid  out  per bank  head entry fields
- bank_req_ready  in  [NUM_BANKS]  bank takes head entry
- bank_done  in  [NUM_BANKS]  one-cycle pulse: oldest in-flight entry complete
- retire_valid  out  [NUM_BANKS]  entry retired this cycle
- retire_uuid  out  [NUM_BANKS][UUID_W]  UUID of retired entry
- occupancy  out  [NUM_BANKS][log2(MSHR_DEPTH)+1]  pending + in-flight count
- err  out  1  sticky: bank_done received with no in-flight entry

## Operation
- **Bank select:** bank = req_addr[BYTE_OFF_BITS+BLOCK_OFF_BITS +: log2(NUM_BANKS)].
- **Per-bank state:**
  - circular array of MSHR_DEPTH entries holding addr, rw, store.
  - three pointers, each log2(MSHR_DEPTH)+1 bits with a wrap bit: alloc (tail), disp, ret (head). Invariant: ret ≤ disp ≤ alloc.
  - pending = alloc−disp; inflight = disp−ret; occupancy = alloc−ret.
  - rr pointer, log2(NUM_PORTS) bits.
- **Entry life cycle:** FREE → PENDING (accept) → INFLIGHT (dispatch) → FREE (retire).
- **Arbitration:**
  - Per bank, the winner is the first port p, scanning from rr upward with wrap, that has req_valid and targets this bank.
  - req_ready[p] = 1 only for winners of banks with registered occupancy < MSHR_DEPTH.
  - A port loses if another port wins its bank or its bank is full; it holds its request.
- **Accept:**
  - The entry is written at slot alloc[low bits]; alloc increments.
  - rr ← winner+1 mod NUM_PORTS.
  - req_uuid = {bank, slot}, combinational in the accept cycle.
  - At most one accept per bank per cycle; different banks accept in parallel.
- **Dispatch:**
  - bank_req_valid = pending > 0.
  - The fields come from slot disp.
  - On valid&ready, disp increments.
- **Retire:**
  - On bank_done with inflight > 0: retire_valid = 1 and retire_uuid = {bank, ret slot}, both combinational the same cycle; ret increments.
  - bank_done with inflight = 0: ignored; err ← 1.
- **Full/empty:** full when occupancy = MSHR_DEPTH; pointers wrap modulo 2·MSHR_DEPTH.
- **Simultaneous events in one bank:** accept, dispatch and retire may occur in the same cycle. Each uses the registered pointers, so there is no bypass:
  - A retire while full does not enable an accept in that cycle.
  - An entry accepted at cycle t is dispatchable at t+1 at the earliest.
- **Reset:**
  - While RST is high: all pointers, rr and err clear to 0 at the clock edge.
  - All outputs are forced low (req_ready, stall, bank_req_valid, retire_valid, occupancy, err; fields 0) while RST is high.
  - Entry data is not cleared.
  - A request or handshake presented during reset is dropped.

## Timing
- Request-to-dispatch latency is 1 cycle minimum.
- Dispatch-to-retire latency is set by the bank; retirement is in order per bank.
- req_ready, req_uuid, stall, bank_req_* and retire_* are combinational from registered state plus the current inputs.
- occupancy and err are registered.
- Sustained throughput is one accept and one dispatch per bank per cycle.

## Test plan
- **Reset:** assert RST 2 cycles with req_valid=1 → all outputs 0. Release, then port0 reads 0x0000_0010 (bank 1) → req_ready[0]=1, req_uuid=0x4; bank_req_valid[1]=1 next cycle with addr 0x10; occupancy[1]=1.
- **Arbitration:** ports 0 and 1 both target bank 2 every cycle for 4 cycles, bank_req_ready=0 → accepts alternate 0,1,0,1 with UUIDs 0x8,0x9,0xA,0xB. The 5th cycle has no ready and stall=1; occupancy[2]=4.
- **Full with retire:** bank 2 full, 2 entries dispatched; pulse bank_done while port0 requests bank 2 → retire_uuid=0x8 and req_ready=0 that cycle; next cycle req_ready=1 and req_uuid=0x8 (wrapped slot).
- **Parallel banks:** port0 targets bank 0 and port1 targets bank 3 in the same cycle → both ready, UUIDs 0x0 and 0xC.
- **Spurious completion:** bank_done[1] with inflight=0 → retire_valid=0, err=1 next cycle, stays 1 until RST.
- **Reset mid-flight:** 3 entries pending/in-flight in bank 0, assert RST → occupancy 0 and bank_req_valid 0 after the edge; the next accept gets UUID 0x0.
